// File: rtl/testport_writer_pkg.sv
// Shared definitions for the test-port writer: default frame constants, FSM state
// encodings (also used by the TestBed checker) and a saturating counter helper.
package testport_writer_pkg;

  localparam logic [29:0] TEST_PORT_DEF = 30'h0000_00FF;
  localparam logic [31:0] BEGIN_SYM_DEF = 32'h0000_0932;
  localparam logic [31:0] END_SYM_DEF   = 32'h0000_0D5D;
  localparam int          WORDS_W       = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEGIN = 3'd1,
    ST_GAP   = 3'd2,
    ST_WRITE = 3'd3,
    ST_END   = 3'd4,
    ST_DONE  = 3'd5
  } tp_state_e;

  function automatic logic [WORDS_W-1:0] sat_inc(input logic [WORDS_W-1:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/testport_writer_sync_fifo.sv
// Synchronous FIFO with show-ahead head, synchronous clear and async active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module testport_writer_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign head_o    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push_s = push_i && !full_o && !clr_i;
  assign do_pop_s  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only slots behind the write pointer are ever read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/testport_writer.sv
// Transmit side of the test-port result protocol: buffers producer words and emits
// BEGIN_SYM, the words in push order, then END_SYM as writes to TEST_PORT.
module testport_writer
  import testport_writer_pkg::*;
#(
  parameter logic [29:0] TEST_PORT  = TEST_PORT_DEF,
  parameter logic [31:0] BEGIN_SYM  = BEGIN_SYM_DEF,
  parameter logic [31:0] END_SYM    = END_SYM_DEF,
  parameter int          FIFO_DEPTH = 8,
  parameter int          GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               push_valid_i,
  input  logic [31:0]        push_data_i,
  input  logic               push_last_i,
  output logic               push_ready_o,
  input  logic               mem_stall_i,
  output logic [29:0]        addr_o,
  output logic [31:0]        data_o,
  output logic               wen_o,
  output logic               busy_o,
  output logic [WORDS_W-1:0] words_sent_o,
  output logic               finish_o
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  tp_state_e          state_q, state_d;
  logic [29:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               wen_q, wen_d;
  logic               busy_q, busy_d;
  logic               finish_q, finish_d;
  logic               last_q, last_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic               push_s;
  logic               pop_s;
  logic               fifo_clr_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [31:0]        fifo_head_s;

  testport_writer_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (fifo_clr_s),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (push_data_i),
    .head_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign push_ready_o = !fifo_full_s && !last_q &&
                        ((state_q == ST_BEGIN) || (state_q == ST_GAP) || (state_q == ST_WRITE));
  assign push_s       = push_valid_i && push_ready_o;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wen_d      = wen_q;
    words_d    = words_q;
    gap_d      = gap_q;
    last_d     = last_q;
    pop_s      = 1'b0;
    fifo_clr_s = 1'b0;

    if (push_s && push_last_i) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d    = ST_BEGIN;
          addr_d     = TEST_PORT;
          data_d     = BEGIN_SYM;
          wen_d      = 1'b1;
          words_d    = '0;
          last_d     = 1'b0;
          fifo_clr_s = 1'b1;
        end else begin
          wen_d = 1'b0;
        end
      end
      ST_BEGIN, ST_END: begin
        if (!mem_stall_i) begin
          state_d = (state_q == ST_BEGIN) ? ST_GAP : ST_DONE;
          wen_d   = 1'b0;
          gap_d   = GAP_INIT;
        end else begin
          wen_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!mem_stall_i) begin
          state_d = ST_GAP;
          wen_d   = 1'b0;
          gap_d   = GAP_INIT;
          words_d = sat_inc(words_q);
        end else begin
          wen_d = 1'b1;
        end
      end
      // The gap counter guarantees wen is low for GAP_CYCLES before the next write.
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_ONE;
        end else if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_WRITE;
          addr_d  = TEST_PORT;
          data_d  = fifo_head_s;
          wen_d   = 1'b1;
        end else if (last_q) begin
          state_d = ST_END;
          addr_d  = TEST_PORT;
          data_d  = END_SYM;
          wen_d   = 1'b1;
        end else begin
          wen_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wen_d   = 1'b0;
      end
    endcase

    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    finish_d = (state_d == ST_DONE);
  end

  // Control and output registers; reset drops wen asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 30'h0;
      data_q   <= 32'h0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      last_q   <= 1'b0;
      words_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
      last_q   <= last_d;
      words_q  <= words_d;
      gap_q    <= gap_d;
    end
  end

  assign addr_o       = addr_q;
  assign data_o       = data_q;
  assign wen_o        = wen_q;
  assign busy_o       = busy_q;
  assign finish_o     = finish_q;
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_testport_writer.sv
// Directed-plus-random bench for testport_writer; the reference is an expected write
// stream (BEGIN, accepted pushes in order, END) checked at every negative clock edge.
module tb_testport_writer;

  localparam logic [31:0] BSYM = 32'h0000_0932;
  localparam logic [31:0] ESYM = 32'h0000_0D5D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        push_valid_i = 1'b0;
  logic [31:0] push_data_i = 32'h0;
  logic        push_last_i = 1'b0;
  logic        mem_stall_i = 1'b0;
  logic        push_ready_o;
  logic [29:0] addr_o;
  logic [31:0] data_o;
  logic        wen_o;
  logic        busy_o;
  logic [9:0]  words_sent_o;
  logic        finish_o;

  always #5 clk = ~clk;

  testport_writer dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .push_last_i  (push_last_i),
    .push_ready_o (push_ready_o),
    .mem_stall_i  (mem_stall_i),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .wen_o        (wen_o),
    .busy_o       (busy_o),
    .words_sent_o (words_sent_o),
    .finish_o     (finish_o)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0] pend[$];      // producer words still to offer: {last, data}
  logic [31:0] exp_w[$];     // writes the DUT still owes, in order
  int          exp_k[$];     // 0 begin symbol, 1 data word, 2 end symbol
  logic [9:0]  words_exp = 10'd0;
  bit          busy_exp = 1'b0, finish_exp = 1'b0, last_exp = 1'b0, gap_req = 1'b0;
  bit          start_req = 1'b0, stall_hold = 1'b0, stall_rand = 1'b0, check_hold = 1'b0;
  int          wr_idx = 0, cur_hold = 0, stall_target = -1, stall_left = 0, pushes_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    pend.delete(); exp_w.delete(); exp_k.delete();
    words_exp = 10'd0; busy_exp = 1'b0; finish_exp = 1'b0; last_exp = 1'b0;
    gap_req = 1'b0; wr_idx = 0; cur_hold = 0;
  endtask

  task automatic push_words(input int n, input bit with_last, input int kind);
    logic [63:0] a, b, t;
    logic [31:0] fib[$];
    a = 64'd0; b = 64'd1;
    for (int i = 0; i < n / 2; i++) begin
      fib.push_back(a[31:0]); t = a + b; a = b; b = t;
    end
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      if (kind == 1) w = (i < n / 2) ? fib[i] : fib[n - 1 - i];
      else if (kind == 2) w = i[31:0];
      else w = $urandom;
      pend.push_back({(with_last && (i == n - 1)), w});
    end
  endtask

  // One clock: drive inputs, check and update the model at negedge, return #1 after posedge.
  task automatic step();
    start_i = start_req; start_req = 1'b0;
    push_valid_i = (pend.size() != 0);
    if (push_valid_i) begin
      push_data_i = pend[0][31:0]; push_last_i = pend[0][32];
    end else begin
      push_data_i = 32'h0; push_last_i = 1'b0;
    end
    if (stall_hold) mem_stall_i = 1'b1;
    else if (wen_o && wr_idx == stall_target && stall_left > 0) begin
      mem_stall_i = 1'b1; stall_left--;
    end else if (stall_rand) mem_stall_i = ($urandom_range(0, 2) == 0);
    else mem_stall_i = 1'b0;

    @(negedge clk);
    chk("busy", busy_o, busy_exp);
    chk("finish", finish_o, finish_exp);
    chk("words_sent", words_sent_o, words_exp);
    chk("ready_outside_frame", push_ready_o && (!busy_exp || last_exp), 1'b0);
    if (gap_req) begin
      chk("gap_wen_low", wen_o, 1'b0);
      gap_req = 1'b0;
    end else if (wen_o) begin
      if (exp_w.size() == 0) chk("spurious_write", wen_o, 1'b0);
      else begin
        chk("addr", addr_o, 30'h0FF);
        chk("data", data_o, exp_w[0]);
        cur_hold++;
        if (!mem_stall_i) begin
          if (check_hold && wr_idx == stall_target) chk("stall_hold_cycles", cur_hold, 4);
          if (exp_k[0] == 1 && words_exp != 10'd1023) words_exp++;
          if (exp_k[0] == 2) begin busy_exp = 1'b0; finish_exp = 1'b1; end
          cur_hold = 0; wr_idx++; gap_req = 1'b1;
          void'(exp_w.pop_front()); void'(exp_k.pop_front());
        end
      end
    end
    if (push_valid_i && push_ready_o) begin
      pushes_acc++;
      exp_w.push_back(push_data_i); exp_k.push_back(1);
      if (push_last_i) begin
        exp_w.push_back(ESYM); exp_k.push_back(2); last_exp = 1'b1;
      end
      void'(pend.pop_front());
    end
    if (start_i && !busy_exp) begin
      busy_exp = 1'b1; finish_exp = 1'b0; words_exp = 10'd0; last_exp = 1'b0;
      exp_w.delete(); exp_k.delete();
      exp_w.push_back(BSYM); exp_k.push_back(0);
      wr_idx = 0; cur_hold = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (finish_exp && pend.size() == 0) break;
      step();
    end
    chk("frame_finish", finish_o, 1'b1);
    chk("stream_drained", exp_w.size(), 0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen", wen_o, 1'b0); chk("rst_addr", addr_o, 30'h0); chk("rst_data", data_o, 32'h0);
    chk("rst_ready", push_ready_o, 1'b0); chk("rst_words", words_sent_o, 10'd0);
    chk("rst_busy", busy_o, 1'b0); chk("rst_finish", finish_o, 1'b0);
    rst = 1'b1;
    step();

    // 1: basic frame 0,1,1,2 offered before start (must wait until BEGIN)
    pend.push_back({1'b0, 32'd0}); pend.push_back({1'b0, 32'd1});
    pend.push_back({1'b0, 32'd1}); pend.push_back({1'b1, 32'd2});
    step(); step();
    start_req = 1'b1;
    run_frame(100);
    chk("s1_words", words_sent_o, 10'd4);

    // 2: three stall cycles on the second data write; stray start mid-frame is ignored
    stall_target = 2; stall_left = 3; check_hold = 1'b1;
    push_words(5, 1'b1, 2);
    start_req = 1'b1;
    step(); step(); step();
    start_req = 1'b1;
    run_frame(100);
    chk("s2_words", words_sent_o, 10'd5);
    stall_target = -1; check_hold = 1'b0;

    // 3: stall held while producer offers 10 words; FIFO caps at 8
    stall_hold = 1'b1;
    pushes_acc = 0;
    push_words(10, 1'b1, 0);
    start_req = 1'b1;
    repeat (20) step();
    chk("s3_buffered", pushes_acc, 8);
    chk("s3_ready_full", push_ready_o, 1'b0);
    stall_hold = 1'b0;
    run_frame(200);
    chk("s3_words", words_sent_o, 10'd10);

    // 4a: single word with last pushed right after start
    pend.push_back({1'b1, 32'd7});
    start_req = 1'b1;
    run_frame(50);
    chk("s4a_words", words_sent_o, 10'd1);

    // 4b: start with no pushes: BEGIN only, then idle in GAP with busy high
    start_req = 1'b1;
    repeat (20) step();
    chk("s4b_busy", busy_o, 1'b1);
    chk("s4b_wen", wen_o, 1'b0);
    chk("s4b_stream", exp_w.size(), 0);

    // 5: reset while wen is high
    stall_hold = 1'b1;
    pend.push_back({1'b0, 32'hABCD_0123});
    for (int i = 0; i < 20; i++) begin
      if (wen_o) break;
      step();
    end
    chk("s5_wen_before", wen_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("s5_wen", wen_o, 1'b0); chk("s5_addr", addr_o, 30'h0); chk("s5_data", data_o, 32'h0);
    chk("s5_busy", busy_o, 1'b0); chk("s5_words", words_sent_o, 10'd0);
    chk("s5_ready", push_ready_o, 1'b0); chk("s5_finish", finish_o, 1'b0);
    stall_hold = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b1;
    step();
    push_words(3, 1'b1, 0);
    start_req = 1'b1;
    run_frame(100);
    chk("s5_fresh_words", words_sent_o, 10'd3);

    // 6: 148-word TestBed sequence with random stalls, then a rerun from DONE
    stall_rand = 1'b1;
    push_words(148, 1'b1, 1);
    start_req = 1'b1;
    run_frame(3000);
    chk("s6_words", words_sent_o, 10'd148);
    push_words(6, 1'b1, 0);
    start_req = 1'b1;
    run_frame(200);
    chk("s6_rerun_words", words_sent_o, 10'd6);
    stall_rand = 1'b0;

    // 7: words_sent saturates at 1023
    push_words(1030, 1'b1, 0);
    start_req = 1'b1;
    run_frame(5000);
    chk("s7_saturate", words_sent_o, 10'd1023);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
